// File: rtl/led_trail_driver.sv
// Nine-LED fading trail with PWM dimming and a wrap indicator on LED9.
// The position comes from an upstream counter; each accepted move relights its LED at full brightness.

module led_trail_lane (
  input  logic       cin,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic       dec,
  input  logic [2:0] pwm_cnt,
  output logic       led
);
  logic [2:0] level;

  always_ff @(posedge cin) begin
    if (!rst_n) begin
      level <= '0;
      led   <= 1'b0;
    end else if (en) begin
      // Compare against the pre-update level: one cycle from level to pin
      led <= (level > pwm_cnt);
      if (load)
        level <= 3'd7;
      else if (dec && level != 3'd0)
        level <= level - 3'd1;
    end else begin
      led <= 1'b0;
    end
  end
endmodule

module led_trail_driver #(
  parameter logic [31:0] PWM_DIV     = 32'd5000,
  parameter logic [31:0] DECAY_TICKS = 32'd2500000,
  parameter logic [31:0] WRAP_HOLD   = 32'd12500000
) (
  input  logic       cin,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] count,
  output logic [9:0] led,
  output logic       step_pulse,
  output logic       wrap_pulse,
  output logic       bad_count
);
  localparam int NUM_LANES = 9;

  logic [3:0]           count_q;
  logic [2:0]           pwm_cnt;
  logic [31:0]          pwm_psc;
  logic [31:0]          dec_psc;
  logic [31:0]          wrap_tmr;
  logic                 wrap_led;
  logic                 pwm_tick;
  logic                 dec_tick;
  logic                 accept;
  logic                 wrap;
  logic [3:0]           head_nxt;
  logic [NUM_LANES-1:0] lane_load;
  logic [NUM_LANES-1:0] lane_dec;
  logic [NUM_LANES-1:0] lane_led;

  assign pwm_tick = (pwm_psc == PWM_DIV - 32'd1);
  assign dec_tick = (dec_psc == DECAY_TICKS - 32'd1);
  assign accept   = en && (count <= 4'd8) && (count != count_q);
  assign wrap     = accept && (count < count_q);
  // Decay skips the head after this edge, so a coinciding step decays the old head
  assign head_nxt = accept ? count : count_q;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_load[i] = accept && (count == 4'(i));
      assign lane_dec[i]  = dec_tick && (head_nxt != 4'(i));

      led_trail_lane u_lane (
        .cin     (cin),
        .rst_n   (rst_n),
        .en      (en),
        .load    (lane_load[i]),
        .dec     (lane_dec[i]),
        .pwm_cnt (pwm_cnt),
        .led     (lane_led[i])
      );
    end
  endgenerate

  always_ff @(posedge cin) begin
    if (!rst_n) begin
      count_q    <= '0;
      pwm_cnt    <= '0;
      pwm_psc    <= '0;
      dec_psc    <= '0;
      wrap_tmr   <= '0;
      wrap_led   <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      bad_count  <= 1'b0;
    end else if (en) begin
      pwm_psc <= pwm_tick ? 32'd0 : pwm_psc + 32'd1;
      if (pwm_tick)
        pwm_cnt <= pwm_cnt + 3'd1;
      dec_psc <= dec_tick ? 32'd0 : dec_psc + 32'd1;
      if (accept)
        count_q <= count;
      step_pulse <= accept;
      wrap_pulse <= wrap;
      wrap_led   <= (wrap_tmr != 32'd0);
      if (wrap)
        wrap_tmr <= WRAP_HOLD;
      else if (wrap_tmr != 32'd0)
        wrap_tmr <= wrap_tmr - 32'd1;
      if (count > 4'd8)
        bad_count <= 1'b1;
    end else begin
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_led   <= 1'b0;
    end
  end

  assign led = {wrap_led, lane_led};
endmodule

// File: tb/tb_led_trail_driver.sv
// Randomized and directed checks of led_trail_driver against a cycle-count based reference model.

module tb_led_trail_driver;
  localparam logic [31:0] PWM_DIV     = 32'd1;
  localparam logic [31:0] DECAY_TICKS = 32'd8;
  localparam logic [31:0] WRAP_HOLD   = 32'd4;

  logic       cin = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] count = 4'd0;
  logic [9:0] led;
  logic       step_pulse, wrap_pulse, bad_count;

  led_trail_driver #(
    .PWM_DIV     (PWM_DIV),
    .DECAY_TICKS (DECAY_TICKS),
    .WRAP_HOLD   (WRAP_HOLD)
  ) dut (
    .cin        (cin),
    .rst_n      (rst_n),
    .en         (en),
    .count      (count),
    .led        (led),
    .step_pulse (step_pulse),
    .wrap_pulse (wrap_pulse),
    .bad_count  (bad_count)
  );

  always #5 cin = ~cin;

  int errors = 0;
  int checks = 0;

  // Reference model: everything is derived from n, the number of enabled cycles since reset.
  int   head, n, k;
  bit   has_wrap;
  int   lvl [9];
  logic [9:0] exp_led;
  logic exp_step, exp_wrap, exp_bad;

  task automatic cyc(input logic r, input logic e, input logic [3:0] c);
    int  cc, pwm, nh;
    bit  acc, wr, dt;
    rst_n = r; en = e; count = c;
    cc = int'(c);
    if (!r) begin
      head = 0; n = 0; k = 0; has_wrap = 0;
      for (int i = 0; i < 9; i++) lvl[i] = 0;
      exp_led = '0; exp_step = 0; exp_wrap = 0; exp_bad = 0;
    end else if (!e) begin
      exp_led = '0; exp_step = 0; exp_wrap = 0;
    end else begin
      pwm = (n / int'(PWM_DIV)) % 8;
      for (int i = 0; i < 9; i++) exp_led[i] = (lvl[i] > pwm);
      exp_led[9] = has_wrap && (n - k) >= 1 && (n - k) <= int'(WRAP_HOLD);
      acc = (cc <= 8) && (cc != head);
      wr  = acc && (cc < head);
      dt  = (n % int'(DECAY_TICKS)) == int'(DECAY_TICKS) - 1;
      nh  = acc ? cc : head;
      for (int i = 0; i < 9; i++) begin
        if (acc && i == cc) lvl[i] = 7;
        else if (dt && i != nh && lvl[i] > 0) lvl[i] = lvl[i] - 1;
      end
      if (wr) begin k = n; has_wrap = 1; end
      if (cc > 8) exp_bad = 1;
      exp_step = acc; exp_wrap = wr; head = nh; n++;
    end
    @(posedge cin);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 4'd0);
    checks++;
    if ({led, step_pulse, wrap_pulse, bad_count} !== 13'd0) begin
      errors++; $display("FAIL reset outputs act=%b exp=0", {led, step_pulse, wrap_pulse, bad_count});
    end
  endtask

  task automatic test_step();
    int hits = 0;
    cyc(1'b1, 1'b1, 4'd0);
    checks++;
    if (step_pulse !== 1'b0) begin errors++; $display("FAIL step_count0 act=%b exp=0", step_pulse); end
    cyc(1'b1, 1'b1, 4'd3);
    checks++;
    if (step_pulse !== 1'b1 || wrap_pulse !== 1'b0) begin
      errors++; $display("FAIL step_first act=%b%b exp=10", step_pulse, wrap_pulse);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 4'd3);
      hits += int'(led[3]);
      checks++;
      if (led !== exp_led || step_pulse !== 1'b0) begin
        errors++; $display("FAIL step_hold led act=%b exp=%b step=%b", led, exp_led, step_pulse);
      end
    end
    checks++;
    if (hits != 7) begin errors++; $display("FAIL step_duty act=%0d exp=7", hits); end
  endtask

  task automatic test_decay();
    cyc(1'b1, 1'b1, 4'd4);
    checks++;
    if (step_pulse !== 1'b1) begin errors++; $display("FAIL decay_step act=%b exp=1", step_pulse); end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1, 4'd4);
      checks++;
      if (led !== exp_led) begin errors++; $display("FAIL decay_led cyc=%0d act=%b exp=%b", i, led, exp_led); end
    end
    checks++;
    if (lvl[3] != 5 || lvl[4] != 7) begin
      errors++; $display("FAIL decay_model lvl3=%0d exp=5 lvl4=%0d exp=7", lvl[3], lvl[4]);
    end
  endtask

  task automatic test_wrap();
    cyc(1'b1, 1'b1, 4'd8);
    cyc(1'b1, 1'b1, 4'd0);
    checks++;
    if (step_pulse !== 1'b1 || wrap_pulse !== 1'b1) begin
      errors++; $display("FAIL wrap_pulses act=%b%b exp=11", step_pulse, wrap_pulse);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 4'd0);
      checks++;
      if (led[9] !== (i < 4) || led !== exp_led || wrap_pulse !== 1'b0) begin
        errors++; $display("FAIL wrap_hold cyc=%0d led=%b exp=%b led9exp=%0d", i, led, exp_led, i < 4);
      end
    end
  endtask

  task automatic test_bad();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 4'd12);
      checks++;
      if (bad_count !== 1'b1 || step_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin
        errors++; $display("FAIL bad_count act=%b%b%b exp=100", bad_count, step_pulse, wrap_pulse);
      end
    end
    cyc(1'b1, 1'b1, 4'd2);
    checks++;
    if (step_pulse !== 1'b1 || wrap_pulse !== 1'b0 || bad_count !== 1'b1 || led !== exp_led) begin
      errors++; $display("FAIL bad_then_step act=%b%b%b led=%b exp=101 led=%b",
                         step_pulse, wrap_pulse, bad_count, led, exp_led);
    end
  endtask

  task automatic test_enable();
    cyc(1'b1, 1'b1, 4'd5);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'd5);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      checks++;
      if (led !== 10'd0 || step_pulse !== 1'b0 || wrap_pulse !== 1'b0 || bad_count !== exp_bad) begin
        errors++; $display("FAIL en_low led=%b step=%b wrap=%b bad=%b exp led=0 bad=%b",
                           led, step_pulse, wrap_pulse, bad_count, exp_bad);
      end
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, 4'd5);
      checks++;
      if (led !== exp_led || step_pulse !== exp_step) begin
        errors++; $display("FAIL en_resume cyc=%0d led=%b exp=%b step=%b", i, led, exp_led, step_pulse);
      end
    end
  endtask

  task automatic test_reset_wrap();
    cyc(1'b1, 1'b1, 4'd8);
    cyc(1'b1, 1'b1, 4'd1);
    cyc(1'b1, 1'b1, 4'd1);
    cyc(1'b0, 1'b1, 4'd1);
    checks++;
    if ({led, step_pulse, wrap_pulse, bad_count} !== 13'd0) begin
      errors++; $display("FAIL reset_midwrap act=%b exp=0", {led, step_pulse, wrap_pulse, bad_count});
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 4'd0);
      checks++;
      if (step_pulse !== 1'b0 || led !== 10'd0) begin
        errors++; $display("FAIL reset_count0 step=%b led=%b exp=0", step_pulse, led);
      end
    end
  endtask

  task automatic test_random();
    logic       r, e;
    logic [3:0] c;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 19) < 18) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
      cyc(r, e, c);
      checks++;
      if (led !== exp_led || step_pulse !== exp_step || wrap_pulse !== exp_wrap || bad_count !== exp_bad) begin
        errors++; $display("FAIL random cyc=%0d act=%b_%b%b%b exp=%b_%b%b%b", i,
                           led, step_pulse, wrap_pulse, bad_count, exp_led, exp_step, exp_wrap, exp_bad);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_step();
    test_decay();
    test_wrap();
    test_bad();
    test_enable();
    test_reset_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
